// File: rtl/fifo_gray_pkg.sv
// Shared definitions for the Gray-coded FIFO pointer controller:
// side selection constants and width-generic Gray/binary conversions.
package fifo_gray_pkg;

  localparam int SIDE_WR = 0;
  localparam int SIDE_RD = 1;

  typedef enum logic {
    SIDE_WRITE = 1'b0,
    SIDE_READ  = 1'b1
  } side_e;

  // Conversions are wrapped in a parameterised class so any pointer width
  // can reuse the same code through gray_conv#(W)::<function>.
  class gray_conv #(parameter int W = 4);

    static function logic [W-1:0] bin2gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
    endfunction

    // XOR prefix from the MSB down.
    static function logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) begin
        b[i] = b[i+1] ^ g[i];
      end
      return b;
    endfunction

  endclass

endpackage

// File: rtl/fifo_gray_sync2.sv
// Two-flop synchroniser for a Gray pointer crossing into this clock domain.
// Both stages clear on reset.
module fifo_gray_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Shift the foreign pointer through two local flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_gray_ptr_ctrl.sv
// Pointer controller for one side of an asynchronous FIFO.
// SIDE=0 is the write side (flag = full), SIDE=1 the read side (flag = empty).
// Keeps a binary pointer with a wrap bit, a registered Gray copy to export,
// the RAM address, an almost flag, the occupancy and an over/underflow pulse.
// Optional macro FIFO_PTR_SYNC_EN adds an internal two-flop synchroniser on
// remote_gray; without it the caller supplies an already synchronised pointer.
module fifo_gray_ptr_ctrl
  import fifo_gray_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  parameter  int SIDE       = 0,
  parameter  int ALMOST_THR = 2,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH),
  localparam int PTR_W      = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic [PTR_W-1:0]  remote_gray,
  output logic [ADDR_W-1:0] addr,
  output logic [PTR_W-1:0]  gray_ptr,
  output logic              flag,
  output logic              almost,
  output logic [PTR_W-1:0]  level,
  output logic              err
);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_gray_ptr_ctrl: FIFO_DEPTH must be a power of two >= 4");
  end
  if (SIDE != SIDE_WR && SIDE != SIDE_RD) begin : g_bad_side
    $error("fifo_gray_ptr_ctrl: SIDE must be 0 or 1");
  end
  if (ALMOST_THR < 1 || ALMOST_THR > FIFO_DEPTH - 1) begin : g_bad_thr
    $error("fifo_gray_ptr_ctrl: ALMOST_THR must be in 1..FIFO_DEPTH-1");
  end

  localparam logic [PTR_W-1:0] FULL_THR  = PTR_W'(FIFO_DEPTH - ALMOST_THR);
  localparam logic [PTR_W-1:0] EMPTY_THR = PTR_W'(ALMOST_THR);
  // Read side comes out of reset empty; write side comes out not full.
  localparam logic             RST_FLAG  = (SIDE == SIDE_RD);

  logic [PTR_W-1:0] remote_g;

`ifdef FIFO_PTR_SYNC_EN
  fifo_gray_sync2 #(.W(PTR_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (remote_gray),
    .q_o   (remote_g)
  );
`else
  assign remote_g = remote_gray;
`endif

  logic [PTR_W-1:0] bin_q, bin_d;
  logic [PTR_W-1:0] gray_q, gray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] remote_bin;
  logic             flag_q, flag_d;
  logic             almost_q, almost_d;
  logic             err_q, err_d;
  logic             adv;

  // Next pointer, flags and occupancy; flags compare against the pointer
  // being registered so a same-cycle local move and remote move resolve together.
  always_comb begin
    adv        = inc & ~flag_q;
    err_d      = inc & flag_q;
    bin_d      = bin_q + {{(PTR_W-1){1'b0}}, adv};
    gray_d     = gray_conv#(PTR_W)::bin2gray(bin_d);
    remote_bin = gray_conv#(PTR_W)::gray2bin(remote_g);
    flag_d     = 1'b0;
    level_d    = '0;
    almost_d   = 1'b0;
    if (SIDE == SIDE_WR) begin
      // Full: same address, opposite wrap -> top two Gray bits inverted.
      flag_d   = (gray_d == {~remote_g[PTR_W-1:PTR_W-2], remote_g[PTR_W-3:0]});
      level_d  = bin_d - remote_bin;
      almost_d = (level_d >= FULL_THR);
    end else begin
      flag_d   = (gray_d == remote_g);
      level_d  = remote_bin - bin_d;
      almost_d = (level_d <= EMPTY_THR);
    end
  end

  // Pointer and status registers; reset discards state immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= RST_FLAG;
      almost_q <= RST_FLAG;
      err_q    <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      err_q    <= err_d;
    end
  end

  assign addr     = bin_q[ADDR_W-1:0];
  assign gray_ptr = gray_q;
  assign flag     = flag_q;
  assign almost   = almost_q;
  assign level    = level_q;
  assign err      = err_q;

endmodule
